// File: rtl/sll32_iter.sv
// sll32_iter: multi-cycle 32-bit logical left shifter for the SLL/SLLV ALU path.
// The operand is shifted STEP bits per cycle under a start/busy/done handshake.
// Optional build macro SLL32_ROTATE_EN: when defined, rot=1 at start selects a
// rotate-left instead of a zero-filling shift (same latency and handshake).
// The variable-shift select is named var_i because 'var' is a reserved word.
module sll32_iter #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        var_i,
    input  logic        rot,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] o,
    output logic        busy,
    output logic        done
);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
            $error("sll32_iter: STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  rem_q, rem_d;
    logic [4:0]  shamt;
    logic [4:0]  step_amt;
    logic [4:0]  rem_left;
    logic [31:0] shifted;

`ifdef SLL32_ROTATE_EN
    logic        rot_q, rot_d;

    // Rotate left by s (1..16 while shifting); bits leaving the MSB re-enter at the LSB.
    function automatic logic [31:0] rotl(input logic [31:0] a, input logic [4:0] s);
        logic [5:0] back;
        back = 6'd32 - {1'b0, s};
        return (a << s) | (a >> back);
    endfunction
`endif

    // Upper instruction/register bits never contribute to the shift amount.
`ifdef SLL32_ROTATE_EN
    logic unused_bits;
    assign unused_bits = ^{B[31:11], B[5]};
`else
    logic unused_bits;
    assign unused_bits = ^{B[31:11], B[5], rot};
`endif

    assign shamt    = var_i ? B[4:0] : B[10:6];
    assign step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    assign rem_left = rem_q - step_amt;

`ifdef SLL32_ROTATE_EN
    assign shifted = rot_q ? rotl(acc_q, step_amt) : (acc_q << step_amt);
`else
    assign shifted = acc_q << step_amt;
`endif

    // Next-state logic: operand capture in IDLE, one partial shift per SHIFT cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
`ifdef SLL32_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = A;
                    rem_d   = shamt;
`ifdef SLL32_ROTATE_EN
                    rot_d   = rot;
`endif
                    state_d = (shamt != 5'd0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_d = shifted;
                rem_d = rem_left;
                if (rem_left == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            rem_q   <= 5'd0;
`ifdef SLL32_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
`ifdef SLL32_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign o    = acc_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_sll32_iter.sv
// Testbench for sll32_iter: directed steps with a result scoreboard.
module tb_sll32_iter;

    localparam int STEP = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        var_i = 1'b0;
    logic        rot   = 1'b0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic [31:0] o;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    sll32_iter #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .var_i (var_i),
        .rot   (rot),
        .A     (A),
        .B     (B),
        .o     (o),
        .busy  (busy),
        .done  (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input int n, input logic r);
        logic [31:0] res;
        res = a << n;
`ifdef SLL32_ROTATE_EN
        if (r && n != 0) res = res | (a >> (32 - n));
`else
        if (r) res = res;
`endif
        return res;
    endfunction

    // Called in the cycle right after the accepting edge; waits for done and
    // checks latency, result, pulse width and hold in the following IDLE cycle.
    task automatic finish_op(input string tag, input int want_cyc);
        int          cyc;
        logic        busy_ok;
        logic [31:0] e;
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 64) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick;
            cyc++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check({tag, " done seen"}, {31'd0, done}, 32'd1);
        if (done === 1'b1) begin
            check({tag, " busy while shifting"}, {31'd0, busy_ok}, 32'd1);
            check({tag, " latency"}, 32'(cyc), 32'(want_cyc));
            check({tag, " busy in done"}, {31'd0, busy}, 32'd1);
            check({tag, " result"}, o, e);
            tick;
            check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
            check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
            check({tag, " result held"}, o, e);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic v, input logic r);
        int n;
        n = v ? int'(b[4:0]) : int'(b[10:6]);
        A = a; B = b; var_i = v; rot = r; start = 1'b1;
        exp_q.push_back(model(a, n, r));
        tick;
        start = 1'b0;
        finish_op(tag, (n + STEP - 1) / STEP + 1);
    endtask

    initial begin
        logic seen;

        // Reset state
        rst_n = 1'b0;
        tick;
        tick;
        check("reset o", o, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Directed shifts
        run_op("sll n4", 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
        check("sll n4 value", o, 32'h0000_0010);
        run_op("sllv n31", 32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("sllv n31 value", o, 32'h8000_0000);
        run_op("sll n0", 32'hDEAD_BEEF, 32'hFFFF_F83F, 1'b0, 1'b0);
        check("sll n0 value", o, 32'hDEAD_BEEF);
        run_op("sllv n3 upper junk", 32'h1234_5678, 32'hFFFF_FFE3, 1'b1, 1'b0);
        run_op("sll n5", 32'h0F0F_0F0F, 32'h0000_0140, 1'b0, 1'b0);
        run_op("sll n17", 32'hCAFE_F00D, 32'h0000_0440, 1'b0, 1'b0);

        // Reset in the third SHIFT cycle of an n=20 shift
        A = 32'hFFFF_FFFF; B = 32'd20; var_i = 1'b1; rot = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort o", o, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) seen = 1'b1;
            tick;
        end
        check("abort no done", {31'd0, seen}, 32'd0);
        run_op("after abort", 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0);
        check("after abort value", o, 32'h0000_0006);

        // start held high with changing operands
        A = 32'h0000_00F0; B = 32'd8; var_i = 1'b1; rot = 1'b0; start = 1'b1;
        exp_q.push_back(32'h0000_F000);
        tick;
        A = 32'h1111_1111;
        finish_op("held first", 3);
        A = 32'h0000_0005; B = 32'd2;
        exp_q.push_back(32'h0000_0014);
        tick;
        start = 1'b0;
        check("held second busy", {31'd0, busy}, 32'd1);
        finish_op("held second", 2);

        // Rotate select
        run_op("rot n1", 32'h8000_0001, 32'h0000_0040, 1'b0, 1'b1);
`ifdef SLL32_ROTATE_EN
        check("rot n1 value", o, 32'h0000_0003);
`else
        check("rot n1 value", o, 32'h0000_0002);
`endif
        run_op("rot n13", 32'hA5A5_0FF1, 32'd13, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
